// File: rtl/clkgen_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : clkgen_rst_seq
// Description : Reset sequencer and clock-enable generator for the clk_sys
//               domain. Synchronises and filters PLL lock and the board reset,
//               then releases N_CH reset domains one at a time, STEP_CYCLES
//               apart. Each released domain receives a programmable
//               clock-enable strobe with a period of (div_q + 1) cycles.
//
// Ports       : clk_sys     in   system clock
//               rst_sys_n   in   synchronous active-low reset
//               pll_locked  in   PLL LOCKED, asynchronous to clk_sys
//               ext_rst_n   in   board reset button, asynchronous, active-low
//               div_cfg     in   per-channel divider, channel i at [i*DIV_W +: DIV_W]
//               rst_ch_n    out  per-channel active-low reset (registered)
//               clk_en      out  per-channel clock-enable strobe (registered)
//               seq_done    out  high while in RUN
//               lock_lost   out  sticky: lock dropped after sequencing began
//               state       out  0 IDLE, 1 FILTER, 2 RELEASE, 3 RUN
//
// Revision    : 1.0 - initial release
// ============================================================================
module clkgen_rst_seq #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 16,
    parameter int STEP_CYCLES = 8,
    parameter int CNT_W       = 8,
    parameter int DIV_W       = 8
) (
    input  logic                   clk_sys,
    input  logic                   rst_sys_n,
    input  logic                   pll_locked,
    input  logic                   ext_rst_n,
    input  logic [N_CH*DIV_W-1:0]  div_cfg,
    output logic [N_CH-1:0]        rst_ch_n,
    output logic [N_CH-1:0]        clk_en,
    output logic                   seq_done,
    output logic                   lock_lost,
    output logic [1:0]             state
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_CH - 1);
    localparam logic [N_CH-1:0]  CH_ONE      = N_CH'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILTER  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic [SYNC_STAGES-1:0] ext_sync_q;
    logic                   locked_s;
    logic                   ext_rst_n_s;
    logic                   ok;

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            lock_sync_q <= '0;
            ext_sync_q  <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
            ext_sync_q  <= {ext_sync_q[SYNC_STAGES-2:0], ext_rst_n};
        end
    end

    assign locked_s    = lock_sync_q[SYNC_STAGES-1];
    assign ext_rst_n_s = ext_sync_q[SYNC_STAGES-1];
    assign ok          = locked_s & ext_rst_n_s;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_CH-1:0]    rst_ch_q, rst_ch_d;
    logic               lock_lost_q, lock_lost_d;

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            rst_ch_q    <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rst_ch_q    <= rst_ch_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        rst_ch_d    = rst_ch_q;
        lock_lost_d = lock_lost_q;

        case (state_q)
            ST_IDLE: begin
                if (ok) begin
                    state_d = ST_FILTER;
                    cnt_d   = '0;
                end
            end

            ST_FILTER: begin
                // Any low cycle restarts the filter from zero.
                if (!ok) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == FILTER_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RELEASE, ST_RUN: begin
                if (!ok) begin
                    // Fault takes priority over a release due this cycle.
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    idx_d    = '0;
                    rst_ch_d = '0;
                    if (!locked_s) begin
                        lock_lost_d = 1'b1;
                    end
                end else if (state_q == ST_RELEASE) begin
                    // cnt counts down the gap to the next release; zero on
                    // entry so channel 0 goes out at the end of the first
                    // RELEASE cycle.
                    if (cnt_q == '0) begin
                        rst_ch_d = rst_ch_q | (CH_ONE << idx_q);
                        cnt_d    = STEP_LAST;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_RUN;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rst_ch_n  = rst_ch_q;
    assign lock_lost = lock_lost_q;
    assign seq_done  = (state_q == ST_RUN);
    assign state     = state_q;

    // ------------------------------------------------------------------
    // Per-channel clock-enable dividers
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
        logic [DIV_W-1:0] div_q, div_d;
        logic             en_q, en_d;

        always_comb begin
            // Held in reset or wrapping: restart count, sample new divider.
            div_cnt_d = '0;
            div_d     = div_cfg[i*DIV_W +: DIV_W];
            if (rst_ch_q[i] && (div_cnt_q != div_q)) begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
                div_d     = div_q;
            end
            // Strobe is registered from next-state values so that it lines
            // up with the cycle in which div_cnt == div_q; with div_q = 0 it
            // rises together with rst_ch_n.
            en_d = rst_ch_d[i] && (div_cnt_d == div_d);
        end

        always_ff @(posedge clk_sys) begin
            if (!rst_sys_n) begin
                div_cnt_q <= '0;
                div_q     <= '0;
                en_q      <= 1'b0;
            end else begin
                div_cnt_q <= div_cnt_d;
                div_q     <= div_d;
                en_q      <= en_d;
            end
        end

        assign clk_en[i] = en_q;
    end

endmodule
`default_nettype wire

// File: doc/clkgen_rst_seq.md
Name: clkgen_rst_seq

Overview:
- Parametrised reset sequencer and clock-enable generator. Sits directly after the PLL/BUFG clock generator in the clk_sys domain.
- Filters the PLL lock and the board reset, then releases N_CH reset domains one at a time with a fixed spacing.
- Drives a programmable clock-enable strobe per domain, so slow peripherals can run from clk_sys without extra PLL outputs or BUFGs.

Parameters:
N_CH, 4, number of reset/clock-enable channels (1..16)
SYNC_STAGES, 2, flip-flop stages on each asynchronous input (>=2)
LOCK_FILTER, 16, consecutive clean cycles required before sequencing starts (1..2^CNT_W-1)
STEP_CYCLES, 8, cycles between successive channel releases (1..2^CNT_W-1)
CNT_W, 8, width of the filter/step counter
DIV_W, 8, width of each channel's clock-enable divider

Ports:
clk_sys  in  1  system clock
rst_sys_n  in  1  synchronous active-low reset
pll_locked  in  1  PLL LOCKED, asynchronous to clk_sys
ext_rst_n  in  1  board reset button, asynchronous, active-low
div_cfg  in  N_CH*DIV_W  per-channel divider; channel i uses bits [i*DIV_W +: DIV_W]
rst_ch_n  out  N_CH  per-channel active-low reset, registered
clk_en  out  N_CH  per-channel clock-enable strobe, registered
seq_done  out  1  high while in RUN
lock_lost  out  1  sticky: PLL lock dropped after sequencing began
state  out  2  FSM state: 0 IDLE, 1 FILTER, 2 RELEASE, 3 RUN

Behaviour:
- Reset (rst_sys_n=0 at a clk_sys edge):
  - Outputs: rst_ch_n=0, clk_en=0, seq_done=0, lock_lost=0, state=IDLE.
  - All counters and synchroniser flops cleared to 0.
- Synchronisers:
  - pll_locked and ext_rst_n each pass through SYNC_STAGES flops.
  - ok = locked_s & ext_rst_n_s. Input-to-ok latency is exactly SYNC_STAGES cycles.
- FSM transitions:
  - IDLE: if ok, go to FILTER with cnt=0.
  - FILTER: if !ok, go to IDLE. Else if cnt==LOCK_FILTER-1, go to RELEASE with cnt=0, idx=0. Else cnt++.
  - RELEASE:
    - Channel k's rst_ch_n rises exactly STEP_CYCLES*k cycles after the first RELEASE cycle. Channel 0 rises on the edge ending the first RELEASE cycle.
    - After releasing channel N_CH-1, go to RUN on the same edge.
    - Released channels stay high.
  - RUN: seq_done=1. Hold.
- Fault (!ok while in RELEASE or RUN):
  - On the next edge, all rst_ch_n=0, clk_en=0, seq_done=0, state=IDLE.
  - If locked_s==0 caused it, set lock_lost=1. ext_rst_n alone does not set it.
- lock_lost clears only on rst_sys_n.
- Glitch in FILTER (ok low for 1 cycle): return to IDLE. The filter restarts from 0 and does not accumulate.
- Clock enable, channel i:
  - While rst_ch_n[i]=0: div_cnt=0, clk_en[i]=0, and div_q is loaded from div_cfg each cycle.
  - Once released: clk_en[i]=1 in the cycle div_cnt==div_q. On that cycle div_cnt wraps to 0 and div_q reloads from div_cfg. Otherwise div_cnt++.
  - Strobe period is div_q+1 cycles. div_q=0 gives clk_en high every cycle.
  - div_cfg changes take effect only at a wrap. Mid-period changes never shorten or lengthen the current period.
  - First strobe occurs div_q cycles after rst_ch_n[i] rises, which is the cycle rst_ch_n[i]=1 when div_q=0.
- Counter widths: cnt is CNT_W bits and never wraps, given the parameter bounds. div_cnt is DIV_W bits, and div_q=2^DIV_W-1 is valid (period 2^DIV_W).
- Simultaneous events:
  - !ok in the same cycle a channel would be released: the fault wins and no release occurs.
  - rst_sys_n low overrides everything.

Test Plan:
- Defaults, both inputs high after reset -> state FILTER at cycle 3; RELEASE after 16 more cycles; rst_ch_n goes 0001, 0011, 0111, 1111 at 8-cycle spacing; seq_done=1 with the last release.
- Single-cycle ext_rst_n low pulse at filter count 10 -> IDLE, then full 16-cycle filter restart; no channel released early; lock_lost stays 0.
- pll_locked drops in RUN -> 2+1 cycles later all rst_ch_n=0, seq_done=0, lock_lost=1; on relock the full sequence repeats and lock_lost stays 1 until rst_sys_n.
- div_cfg ch0=3, ch1=0 -> ch0 strobe every 4 cycles, first strobe 3 cycles after release; ch1 clk_en continuously high once released.
- Change ch0 div_cfg from 3 to 9 mid-period -> current period stays 4 cycles, next period 10; ch0 div 255 gives a 256-cycle period.
- rst_sys_n asserted mid-RELEASE (2 channels out) -> next edge: all outputs 0, state IDLE, counters cleared.
